// File: rtl/lc3_pkg.sv
// lc3_pkg: shared encodings for the LC-3 datapath
package lc3_pkg;
  typedef enum logic [1:0] {ALU_ADD, ALU_AND, ALU_NOT, ALU_PASS} aluk_e;
  typedef enum logic [1:0] {PC_INC, PC_BUS, PC_ADDER, PC_HOLD} pcmux_e;
  typedef enum logic [1:0] {A2_ZERO, A2_OFF6, A2_OFF9, A2_OFF11} addr2mux_e;
  typedef enum logic {S_IDLE, S_BUSY} mem_state_e;
  localparam int LD_PC  = 0;
  localparam int LD_MAR = 1;
  localparam int LD_MDR = 2;
  localparam int LD_IR  = 3;
  localparam int LD_REG = 4;
  localparam int LD_CC  = 5;
  localparam int LD_BEN = 6;
  localparam int G_PC     = 0;
  localparam int G_MARMUX = 1;
  localparam int G_ALU    = 2;
  localparam int G_MDR    = 3;
endpackage

// File: rtl/lc3_datapath_gen_if.sv
// lc3_datapath_gen_if: control, memory and status signals of the LC-3 datapath
interface lc3_datapath_gen_if #(parameter int WIDTH = 16);
  logic [6:0]       LD;
  logic [3:0]       GATE;
  logic [1:0]       PCMUX;
  logic             ADDR1MUX;
  logic [1:0]       ADDR2MUX;
  logic             DRMUX;
  logic             SR1MUX;
  logic             SR2MUX;
  logic [1:0]       ALUK;
  logic             MEM_START;
  logic             MEM_WE;
  logic             MEM_RDY;
  logic [WIDTH-1:0] MEM_RDATA;
  logic             MEM_EN;
  logic             MEM_WR;
  logic [WIDTH-1:0] MEM_ADDR;
  logic [WIDTH-1:0] MEM_WDATA;
  logic             MEM_BUSY;
  logic             MEM_TO;
  logic             BUS_ERR;
  logic [WIDTH-1:0] IR_out;
  logic [WIDTH-1:0] PC_out;
  logic [2:0]       NZP;
  logic             BEN;
  modport master (
    output LD, GATE, PCMUX, ADDR1MUX, ADDR2MUX, DRMUX, SR1MUX, SR2MUX, ALUK,
           MEM_START, MEM_WE, MEM_RDY, MEM_RDATA,
    input  MEM_EN, MEM_WR, MEM_ADDR, MEM_WDATA, MEM_BUSY, MEM_TO, BUS_ERR,
           IR_out, PC_out, NZP, BEN
  );
  modport slave (
    input  LD, GATE, PCMUX, ADDR1MUX, ADDR2MUX, DRMUX, SR1MUX, SR2MUX, ALUK,
           MEM_START, MEM_WE, MEM_RDY, MEM_RDATA,
    output MEM_EN, MEM_WR, MEM_ADDR, MEM_WDATA, MEM_BUSY, MEM_TO, BUS_ERR,
           IR_out, PC_out, NZP, BEN
  );
endinterface

// File: rtl/lc3_regfile.sv
// lc3_regfile: 8-entry register file, two async read ports, one sync write port
module lc3_regfile #(parameter int WIDTH = 16) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [2:0]       waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [2:0]       raddr1,
  input  logic [2:0]       raddr2,
  output logic [WIDTH-1:0] rdata1,
  output logic [WIDTH-1:0] rdata2
);
  logic [WIDTH-1:0] regs [8];
  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];
  // reads see the pre-edge contents, so a same-cycle write returns the old value
  always_ff @(posedge clk)
    if (rst) regs <= '{default: '0};
    else if (we) regs[waddr] <= wdata;
endmodule

// File: rtl/lc3_datapath_gen.sv
// lc3_datapath_gen: LC-3 datapath with gated bus, register file and memory handshake FSM
module lc3_datapath_gen import lc3_pkg::*; #(
  parameter int WIDTH       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input logic              Clk,
  input logic              Reset,
  lc3_datapath_gen_if.slave dp
);
  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);
  logic [WIDTH-1:0] pc, mar, mdr, ir, sr1, sr2, op2, alu, a1, a2, adder, bus;
  logic [2:0]       nzp, sel1, dr;
  logic             ben, bus_err, mem_en, mem_wr, mem_to, multi;
  logic [7:0]       cnt;
  mem_state_e       state;
  assign sel1  = dp.SR1MUX ? ir[8:6] : ir[11:9];
  assign dr    = dp.DRMUX ? 3'd7 : ir[11:9];
  assign multi = |(dp.GATE & (dp.GATE - 4'd1));
  lc3_regfile #(.WIDTH(WIDTH)) u_rf (
    .clk(Clk), .rst(Reset), .we(dp.LD[LD_REG]), .waddr(dr), .wdata(bus),
    .raddr1(sel1), .raddr2(ir[2:0]), .rdata1(sr1), .rdata2(sr2)
  );
  // address adder, ALU and the single-driver bus
  always_comb begin
    a1    = dp.ADDR1MUX ? sr1 : pc;
    a2    = dp.ADDR2MUX == A2_ZERO ? '0 :
            dp.ADDR2MUX == A2_OFF6 ? {{(WIDTH-6){ir[5]}}, ir[5:0]} :
            dp.ADDR2MUX == A2_OFF9 ? {{(WIDTH-9){ir[8]}}, ir[8:0]} :
                                     {{(WIDTH-11){ir[10]}}, ir[10:0]};
    adder = a1 + a2;
    op2   = dp.SR2MUX ? {{(WIDTH-5){ir[4]}}, ir[4:0]} : sr2;
    alu   = dp.ALUK == ALU_ADD ? sr1 + op2 :
            dp.ALUK == ALU_AND ? sr1 & op2 :
            dp.ALUK == ALU_NOT ? ~sr1 : sr1;
    bus   = (dp.GATE == '0 || multi) ? '0 :
            dp.GATE[G_PC] ? pc : dp.GATE[G_MARMUX] ? adder : dp.GATE[G_ALU] ? alu : mdr;
  end
  // PC, IR, condition codes, branch enable and bus contention flag
  always_ff @(posedge Clk)
    if (Reset) begin
      pc      <= '0;
      ir      <= '0;
      nzp     <= 3'b010;
      ben     <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      bus_err <= multi;
      if (dp.LD[LD_PC])
        pc <= dp.PCMUX == PC_INC ? pc + WIDTH'(1) : dp.PCMUX == PC_BUS ? bus :
              dp.PCMUX == PC_ADDER ? adder : pc;
      if (dp.LD[LD_IR]) ir <= bus;
      if (dp.LD[LD_CC]) nzp <= {bus[WIDTH-1], bus == '0, !bus[WIDTH-1] && bus != '0};
      if (dp.LD[LD_BEN]) ben <= (ir[11] & nzp[2]) | (ir[10] & nzp[1]) | (ir[9] & nzp[0]);
    end
  // memory FSM; MAR and MDR are frozen by the datapath while an access is in flight
  always_ff @(posedge Clk)
    if (Reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      mem_en <= 1'b0;
      mem_wr <= 1'b0;
      mem_to <= 1'b0;
      mar    <= '0;
      mdr    <= '0;
    end else if (state == S_IDLE) begin
      if (dp.LD[LD_MDR]) mdr <= bus;
      if (dp.LD[LD_MAR]) mar <= bus;
      if (dp.MEM_START) begin
        state  <= S_BUSY;
        mem_en <= 1'b1;
        mem_wr <= dp.MEM_WE;
        mem_to <= 1'b0;
        cnt    <= '0;
      end
    end else if (dp.MEM_RDY) begin
      state  <= S_IDLE;
      mem_en <= 1'b0;
      if (!mem_wr) mdr <= dp.MEM_RDATA;
    end else if (cnt == TO_LAST) begin
      state  <= S_IDLE;
      mem_en <= 1'b0;
      mem_to <= 1'b1;
    end else cnt <= cnt + 8'd1;
  assign dp.MEM_EN    = mem_en;
  assign dp.MEM_WR    = mem_wr;
  assign dp.MEM_ADDR  = mar;
  assign dp.MEM_WDATA = mdr;
  assign dp.MEM_BUSY  = state == S_BUSY;
  assign dp.MEM_TO    = mem_to;
  assign dp.BUS_ERR   = bus_err;
  assign dp.IR_out    = ir;
  assign dp.PC_out    = pc;
  assign dp.NZP       = nzp;
  assign dp.BEN       = ben;
endmodule

// File: tb/tb_lc3_datapath_gen.sv
// tb_lc3_datapath_gen: random and directed checking of the LC-3 datapath against a behavioural model
module tb_lc3_datapath_gen;
  localparam int TO16 = 4;
  logic        clk = 1'b0, rst = 1'b1;
  logic [6:0]  ld;
  logic [3:0]  gate;
  logic [1:0]  pcmux, addr2mux, aluk;
  logic        addr1mux, drmux, sr1mux, sr2mux, start, we, rdy;
  logic [31:0] rdata;
  int          vectors = 0, miscompares = 0, n;
  bit          armed = 0;
  always #5 clk = ~clk;
  lc3_datapath_gen_if #(.WIDTH(16)) i16();
  lc3_datapath_gen_if #(.WIDTH(32)) i32();
  always_comb begin
    i16.LD = ld;             i32.LD = ld;
    i16.GATE = gate;         i32.GATE = gate;
    i16.PCMUX = pcmux;       i32.PCMUX = pcmux;
    i16.ADDR1MUX = addr1mux; i32.ADDR1MUX = addr1mux;
    i16.ADDR2MUX = addr2mux; i32.ADDR2MUX = addr2mux;
    i16.DRMUX = drmux;       i32.DRMUX = drmux;
    i16.SR1MUX = sr1mux;     i32.SR1MUX = sr1mux;
    i16.SR2MUX = sr2mux;     i32.SR2MUX = sr2mux;
    i16.ALUK = aluk;         i32.ALUK = aluk;
    i16.MEM_START = start;   i32.MEM_START = start;
    i16.MEM_WE = we;         i32.MEM_WE = we;
    i16.MEM_RDY = rdy;       i32.MEM_RDY = rdy;
    i16.MEM_RDATA = rdata[15:0];
    i32.MEM_RDATA = rdata;
  end
  lc3_datapath_gen #(.WIDTH(16), .MEM_TIMEOUT(TO16)) u16 (.Clk(clk), .Reset(rst), .dp(i16.slave));
  lc3_datapath_gen #(.WIDTH(32), .MEM_TIMEOUT(15))   u32 (.Clk(clk), .Reset(rst), .dp(i32.slave));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sx(input logic [15:0] v, input int w);
    logic signed [15:0] t;
    t = v << (16 - w);
    return t >>> (16 - w);
  endfunction

  logic [15:0] m_pc, m_mar, m_mdr, m_ir;
  logic [15:0] m_r [8];
  logic [2:0]  m_nzp;
  logic        m_ben, m_berr, m_busy, m_wr, m_to;
  int          m_wait;

  always @(posedge clk) begin : model
    logic [15:0] s1, s2, a1, a2, add, op2, alu, b;
    if (rst) begin
      m_pc = 0; m_mar = 0; m_mdr = 0; m_ir = 0;
      for (int i = 0; i < 8; i++) m_r[i] = 0;
      m_nzp = 3'b010; m_ben = 0; m_berr = 0; m_busy = 0; m_wr = 0; m_to = 0; m_wait = 0;
      armed = 1;
    end else begin
      s1 = m_r[sr1mux ? m_ir[8:6] : m_ir[11:9]];
      s2 = m_r[m_ir[2:0]];
      a1 = addr1mux ? s1 : m_pc;
      case (addr2mux)
        2'd0: a2 = 0;
        2'd1: a2 = sx(m_ir, 6);
        2'd2: a2 = sx(m_ir, 9);
        default: a2 = sx(m_ir, 11);
      endcase
      add = a1 + a2;
      op2 = sr2mux ? sx(m_ir, 5) : s2;
      case (aluk)
        2'd0: alu = s1 + op2;
        2'd1: alu = s1 & op2;
        2'd2: alu = ~s1;
        default: alu = s1;
      endcase
      case (gate)
        4'b0001: b = m_pc;
        4'b0010: b = add;
        4'b0100: b = alu;
        4'b1000: b = m_mdr;
        default: b = 0;
      endcase
      m_berr = $countones(gate) > 1;
      if (ld[6]) m_ben = (m_ir[11] && m_nzp == 3'b100) || (m_ir[10] && m_nzp == 3'b010) ||
                         (m_ir[9] && m_nzp == 3'b001);
      if (ld[5]) m_nzp = $signed(b) < 0 ? 3'b100 : b == 0 ? 3'b010 : 3'b001;
      if (ld[4]) m_r[drmux ? 3'd7 : m_ir[11:9]] = b;
      if (ld[3]) m_ir = b;
      if (ld[0]) m_pc = pcmux == 0 ? m_pc + 16'd1 : pcmux == 1 ? b : pcmux == 2 ? add : m_pc;
      if (!m_busy) begin
        if (ld[2]) m_mdr = b;
        if (ld[1]) m_mar = b;
        if (start) begin m_busy = 1; m_wr = we; m_to = 0; m_wait = 0; end
      end else if (rdy) begin
        m_busy = 0;
        if (!m_wr) m_mdr = rdata[15:0];
      end else begin
        m_wait++;
        if (m_wait == TO16) begin m_busy = 0; m_to = 1; end
      end
    end
  end

  always @(negedge clk) if (armed) begin
    chk("pc", i16.PC_out, m_pc);
    chk("ir", i16.IR_out, m_ir);
    chk("nzp", i16.NZP, m_nzp);
    chk("ben", i16.BEN, m_ben);
    chk("bus_err", i16.BUS_ERR, m_berr);
    chk("mem_en", i16.MEM_EN, m_busy);
    chk("mem_busy", i16.MEM_BUSY, m_busy);
    chk("mem_wr", i16.MEM_WR, m_wr);
    chk("mem_to", i16.MEM_TO, m_to);
    chk("mem_addr", i16.MEM_ADDR, m_mar);
    chk("mem_wdata", i16.MEM_WDATA, m_mdr);
  end

  task automatic quiet();
    ld = 0; gate = 0; pcmux = 2'd3; addr1mux = 0; addr2mux = 0; drmux = 0;
    sr1mux = 0; sr2mux = 0; aluk = 0; start = 0; we = 0; rdy = 0; rdata = 0;
  endtask
  task automatic clk1();
    @(posedge clk); @(negedge clk); #1;
  endtask
  task automatic load_mdr(input logic [31:0] v);
    quiet(); start = 1; clk1();
    quiet(); rdy = 1; rdata = v; clk1();
    quiet();
  endtask
  task automatic move(input logic [6:0] l, input logic [1:0] pm);
    quiet(); gate = 4'b1000; ld = l; pcmux = pm; clk1(); quiet();
  endtask

  initial begin
    quiet();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rst = 0;
    chk("rst_nzp", i16.NZP, 3'b010);
    chk("rst_pc", i16.PC_out, 16'h0000);
    chk("rst_busy", i16.MEM_BUSY, 1'b0);
    load_mdr(32'h100);
    move(7'h08, 2'd3);
    load_mdr(32'h12345678);
    move(7'h01, 2'd1);
    quiet(); addr2mux = 2'd2; gate = 4'b0010; ld = 7'h09; pcmux = 2'd2; clk1(); quiet();
    chk("w32_marmux_bus", i32.IR_out, 32'h12345578);
    chk("w32_pc_adder", i32.PC_out, 32'h12345578);
    load_mdr(16'hFFFF);
    move(7'h01, 2'd1);
    chk("pc_ffff", i16.PC_out, 16'hFFFF);
    quiet(); ld = 7'h01; pcmux = 2'd0; clk1(); quiet();
    chk("pc_wrap", i16.PC_out, 16'h0000);
    load_mdr(16'h0200); move(7'h08, 2'd3);
    load_mdr(16'h0005); move(7'h10, 2'd3);
    load_mdr(16'h0400); move(7'h08, 2'd3);
    load_mdr(16'hFFFA); move(7'h10, 2'd3);
    load_mdr(16'h1642); move(7'h08, 2'd3);
    quiet(); sr1mux = 1; gate = 4'b0100; ld = 7'h30; clk1(); quiet();
    chk("add_nzp", i16.NZP, 3'b100);
    load_mdr(16'h00C0); move(7'h08, 2'd3);
    quiet(); sr1mux = 1; aluk = 2'd3; gate = 4'b0100; ld = 7'h08; clk1(); quiet();
    chk("r3_value", i16.IR_out, 16'hFFFF);
    quiet(); ld = 7'h40; clk1(); quiet();
    chk("ben_n", i16.BEN, 1'b1);
    load_mdr(16'h3000); move(7'h02, 2'd3);
    chk("mar", i16.MEM_ADDR, 16'h3000);
    quiet(); start = 1; clk1(); quiet();
    n = 0;
    for (int i = 0; i < 20 && i16.MEM_BUSY; i++) begin
      n++;
      if (n == 3) begin rdy = 1; rdata = 32'h1234; end
      clk1(); quiet();
    end
    chk("read_busy_cycles", n, 3);
    chk("read_mdr", i16.MEM_WDATA, 16'h1234);
    quiet(); start = 1; clk1(); quiet();
    n = 0;
    for (int i = 0; i < 20 && i16.MEM_BUSY; i++) begin n++; clk1(); end
    chk("timeout_cycles", n, TO16);
    chk("timeout_flag", i16.MEM_TO, 1'b1);
    chk("timeout_mdr", i16.MEM_WDATA, 16'h1234);
    chk("timeout_idle", i16.MEM_BUSY, 1'b0);
    quiet(); start = 1; we = 1; clk1(); quiet();
    chk("to_cleared", i16.MEM_TO, 1'b0);
    chk("write_wr", i16.MEM_WR, 1'b1);
    rdy = 1; rdata = 32'hBEEF; clk1(); quiet();
    chk("write_mdr_kept", i16.MEM_WDATA, 16'h1234);
    quiet(); gate = 4'b0011; ld = 7'h08; clk1(); quiet();
    chk("bus_err_set", i16.BUS_ERR, 1'b1);
    chk("bus_zero", i16.IR_out, 16'h0000);
    gate = 4'b0001; clk1(); quiet();
    chk("bus_err_clr", i16.BUS_ERR, 1'b0);
    repeat (3000) begin
      rst = $urandom_range(0, 199) == 0;
      ld = 7'($urandom) & 7'($urandom);
      n = $urandom_range(0, 9);
      gate = n < 6 ? 4'(1 << $urandom_range(0, 3)) : n == 6 ? 4'd0 : 4'($urandom);
      pcmux = 2'($urandom); addr1mux = 1'($urandom); addr2mux = 2'($urandom);
      drmux = 1'($urandom); sr1mux = 1'($urandom); sr2mux = 1'($urandom); aluk = 2'($urandom);
      start = $urandom_range(0, 5) == 0; we = 1'($urandom);
      rdy = $urandom_range(0, 3) == 0; rdata = $urandom;
      clk1();
    end
    rst = 0; quiet(); clk1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
